instruction_fetch: RTL
======================

Name: instruction_fetch

Overview:
Fetch stage directly upstream of instruction_decoder. Holds the program counter and issues single-outstanding word reads to instruction memory. Presents each returned word to the decoder as instr_data with a one-cycle instr_en strobe. Honours decoder back-pressure (stall) and branch/jump redirects from execute.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
PC_INC, 4, byte increment between sequential fetches.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
stall  input  1  decoder cannot accept an instruction this cycle.
redirect  input  1  one-cycle pulse: discard in-flight work, fetch from redirect_pc.
redirect_pc  input  32  target address for redirect.
imem_req  output  1  read request, asserted exactly one cycle per fetch.
imem_addr  output  32  word address of the request; valid while imem_req=1.
imem_rvalid  input  1  read data valid; at least 1 cycle after imem_req.
imem_rdata  input  32  instruction word, sampled when imem_rvalid=1.
instr_data  output  32  instruction to decoder; stable until next instr_en.
instr_en  output  1  one-cycle strobe: instr_data holds a new instruction.
instr_pc  output  32  address of the instruction in instr_data.

Behaviour:
- Reset (rst_n=0, async):
  - pc=RESET_PC; state=REQ on first cycle after release.
  - imem_req=0, imem_addr=RESET_PC, instr_en=0, instr_data=32'h0000_0013 (NOP), instr_pc=RESET_PC, kill=0.
- State REQ:
  - imem_req=1, imem_addr=pc for exactly one cycle; memory always accepts.
  - Next state: WAIT.
- State WAIT:
  - On imem_rvalid with kill=0 and stall=0: instr_data<=imem_rdata, instr_pc<=pc, instr_en=1 next cycle, pc<=pc+PC_INC, go REQ.
  - On imem_rvalid with kill=0 and stall=1: capture word into hold register, go HOLD.
- State HOLD:
  - Waits while stall=1.
  - On first cycle with stall=0: present held word (instr_en=1 next cycle), pc<=pc+PC_INC, go REQ.
- Latency:
  - REQ to instr_en with 1-cycle memory is 3 cycles.
  - Peak throughput is one instruction per 3 cycles.
- Redirect:
  - In REQ: the current request still issues; kill<=1, pc<=redirect_pc.
  - In WAIT: kill<=1, pc<=redirect_pc.
  - While kill=1, the next imem_rvalid is discarded (no instr_en); kill<=0, go REQ.
  - In HOLD: drop the held word, pc<=redirect_pc, go REQ.
  - Same cycle as an accepted imem_rvalid: redirect wins; word dropped, instr_en stays 0.
  - Same cycle as stall: redirect wins.
  - Back-to-back redirects: last one wins.
- instr_en is never high on consecutive cycles. instr_data/instr_pc change only with instr_en.
- PC arithmetic is 32-bit modulo; 32'hFFFF_FFFC+4 wraps to 0.
- imem_rvalid outside WAIT is ignored.
- Reset mid-WAIT: the stale response after release is ignored because state=REQ; the first fetch after release is RESET_PC.

Optional Feature:
FETCH_MISALIGN_TRAP_EN
- Defined:
  - Adds output fetch_misalign (1 bit, reset 0) and state TRAP.
  - A redirect with redirect_pc[1:0]!=0 enters TRAP: no imem_req, fetch_misalign=1 held, instr_en=0.
  - An aligned redirect exits TRAP to REQ and clears fetch_misalign.
  - A misaligned redirect while in TRAP leaves it in TRAP.
- Undefined: no extra port or state; redirect_pc[1:0] is forced to 2'b00.

Decomposition:
- Shared package (rv_pkg), reused by the decoder:
  - fetch state encoding (REQ, WAIT, HOLD, TRAP).
  - NOP constant 32'h0000_0013.
  - XLEN=32.
- Sub-module pc_reg: pc register with load/increment, async active-low reset.
- FSM and hold register stay in instruction_fetch.

Test Plan:
- Sequential fetch: reset release, memory returns rdata=addr^32'hA5A5_0000 after 1 cycle -> imem_addr 0,4,8,12; instr_en every 3rd cycle with matching instr_pc/instr_data.
- Stall/hold: stall=1 when rvalid arrives at addr 8, held 5 cycles -> no instr_en while stalled; instr_en one cycle after stall falls with word for 8; next imem_addr=12.
- Redirect in WAIT: redirect_pc=32'h100 while the addr 4 request is outstanding -> the addr 4 response is dropped, next imem_addr=32'h100, next instr_pc=32'h100.
- Redirect coincident with rvalid: redirect=1 and rvalid=1 same cycle, redirect_pc=32'h200 -> no instr_en; next imem_addr=32'h200.
- Async reset in WAIT: rst_n low mid-cycle -> outputs reach reset values immediately; stale rvalid after release is ignored; first imem_addr=RESET_PC.
- With FETCH_MISALIGN_TRAP_EN: redirect_pc=32'h102 -> fetch_misalign=1, no imem_req for 10 cycles; redirect_pc=32'h104 -> fetch_misalign=0, imem_addr=32'h104.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared definitions for the fetch and decode stages: data width, NOP encoding
// and the fetch FSM state encoding.
package rv_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    FETCH_REQ  = 2'd0,
    FETCH_WAIT = 2'd1,
    FETCH_HOLD = 2'd2,
    FETCH_TRAP = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/pc_reg.sv
// Program counter register: load has priority over sequential increment.
module pc_reg
  import rv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter logic [XLEN-1:0] PC_INC   = 32'd4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic [XLEN-1:0] load_pc,
  input  logic            inc,
  output logic [XLEN-1:0] pc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else if (load) begin
      pc <= load_pc;
    end else if (inc) begin
      pc <= pc + PC_INC;
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: single-outstanding instruction memory reads feeding the decoder.
// Optional misaligned-redirect trap is built when FETCH_MISALIGN_TRAP_EN is defined.
//
// state | meaning
// REQ   | issue one read at pc (imem_req registered, visible next cycle)
// WAIT  | read outstanding; kill marks a response that must be dropped
// HOLD  | word captured while decoder stalled; waiting for stall to fall
// TRAP  | misaligned redirect seen; no fetching until an aligned redirect
module instruction_fetch
  import rv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter logic [XLEN-1:0] PC_INC   = 32'd4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] instr_data,
  output logic            instr_en,
  output logic [XLEN-1:0] instr_pc
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic            fetch_misalign
`endif
);

  fetch_state_t    state, state_nxt;
  logic            kill, kill_nxt;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] hold_data;
  logic [XLEN-1:0] target_pc;
  logic [XLEN-1:0] present_data;
  logic            misaligned;
  logic            redir_ok;
  logic            redir_trap;
  logic            pc_load;
  logic            pc_inc;
  logic            present;
  logic            hold_load;
  logic            req_issue;

`ifdef FETCH_MISALIGN_TRAP_EN
  assign misaligned = |redirect_pc[1:0];
  assign target_pc  = redirect_pc;
`else
  assign misaligned = 1'b0;
  assign target_pc  = redirect_pc & ~XLEN'(3);
`endif

  assign redir_ok   = redirect & ~misaligned;
  assign redir_trap = redirect & misaligned;

  pc_reg #(
    .RESET_PC (RESET_PC),
    .PC_INC   (PC_INC)
  ) u_pc_reg (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (pc_load),
    .load_pc (target_pc),
    .inc     (pc_inc),
    .pc      (pc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FETCH_REQ;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    kill_nxt     = kill;
    pc_load      = 1'b0;
    pc_inc       = 1'b0;
    present      = 1'b0;
    present_data = hold_data;
    hold_load    = 1'b0;
    req_issue    = 1'b0;

    case (state)
      FETCH_REQ: begin
        // The request goes out even if a redirect arrives now; its data is killed.
        req_issue = 1'b1;
        state_nxt = FETCH_WAIT;
        if (redirect) begin
          kill_nxt = 1'b1;
          pc_load  = redir_ok;
        end
      end
      FETCH_WAIT: begin
        if (imem_rvalid) begin
          kill_nxt = 1'b0;
          if (redirect) begin
            pc_load   = redir_ok;
            state_nxt = FETCH_REQ;
          end else if (kill) begin
            state_nxt = FETCH_REQ;
          end else if (stall) begin
            hold_load = 1'b1;
            state_nxt = FETCH_HOLD;
          end else begin
            present      = 1'b1;
            present_data = imem_rdata;
            pc_inc       = 1'b1;
            state_nxt    = FETCH_REQ;
          end
        end else if (redirect) begin
          kill_nxt = 1'b1;
          pc_load  = redir_ok;
        end
      end
      FETCH_HOLD: begin
        if (redirect) begin
          pc_load   = redir_ok;
          state_nxt = FETCH_REQ;
        end else if (!stall) begin
          present   = 1'b1;
          pc_inc    = 1'b1;
          state_nxt = FETCH_REQ;
        end
      end
      default: begin
        // A read issued just before trapping may still return here; absorb it.
        if (imem_rvalid) begin
          kill_nxt = 1'b0;
        end
        if (redir_ok) begin
          pc_load   = 1'b1;
          state_nxt = FETCH_REQ;
        end
      end
    endcase

    if (redir_trap) begin
      state_nxt = FETCH_TRAP;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kill       <= 1'b0;
      hold_data  <= NOP;
      imem_req   <= 1'b0;
      imem_addr  <= RESET_PC;
      instr_en   <= 1'b0;
      instr_data <= NOP;
      instr_pc   <= RESET_PC;
    end else begin
      kill     <= kill_nxt;
      imem_req <= req_issue;
      instr_en <= present;
      if (req_issue) begin
        imem_addr <= pc;
      end
      if (hold_load) begin
        hold_data <= imem_rdata;
      end
      if (present) begin
        instr_data <= present_data;
        instr_pc   <= pc;
      end
    end
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_misalign <= 1'b0;
    end else begin
      fetch_misalign <= (state_nxt == FETCH_TRAP);
    end
  end
`endif

endmodule
